// File: rtl/addsub_norm_round_pkg.sv
// Shared constants for the floating-point adder datapath (aligner, swap, add/sub).
package addsub_norm_round_pkg;
  localparam int WIDTH       = 32;
  localparam int WIDTH_EXP   = 8;
  localparam int WIDTH_MAT   = 23;
  localparam int WIDTH_ROUND = 30;
  localparam int MW          = WIDTH_MAT + 1 + WIDTH_ROUND;
  localparam int LZW         = $clog2(MW + 1);
  localparam int EW1         = WIDTH_EXP + 1;

  localparam logic [WIDTH_EXP-1:0] EXP_ONES = '1;

  // FLAGS bit positions: {OVF, UNF, ZERO}
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_ZERO = 0;

  // IEEE single field positions
  localparam int SIGN_BIT = WIDTH - 1;
  localparam int EXP_LSB  = WIDTH_MAT;

  function automatic logic [WIDTH-1:0] pack_fp(input logic s,
                                               input logic [WIDTH_EXP-1:0] e,
                                               input logic [WIDTH_MAT-1:0] f);
    return {s, e, f};
  endfunction
endpackage

// File: rtl/addsub_norm_round_lzc.sv
// Parametric leading-zero counter; all-zero input returns N.
module lzc_count #(
  parameter int N  = 54,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  din,
  output logic [CW-1:0] count
);
  // Highest set bit wins because later loop iterations overwrite earlier ones.
  always_comb begin
    count = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (din[i]) count = CW'(N - 1 - i);
    end
  end
endmodule

// File: rtl/addsub_norm_round.sv
// Effective add/subtract, normalise and round-to-nearest-even, 3-stage valid/ready pipe.
module addsub_norm_round
  import addsub_norm_round_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 SIGN_L,
  input  logic                 SIGN_S,
  input  logic [WIDTH_EXP-1:0] EXP_L,
  input  logic [MW-1:0]        MAT_L,
  input  logic [MW-1:0]        MAT_S,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [WIDTH-1:0]     RESULT,
  output logic [2:0]           FLAGS
);
  logic adv1, adv2, adv3;

  logic                 v1, sign1;
  logic [MW:0]          sum1;
  logic [WIDTH_EXP-1:0] exp1;

  logic                 v2, sign2, sticky2, zero2, unf2, ovf2;
  logic [MW-1:0]        m2;
  logic [EW1-1:0]       exp2;

  logic                 sign2_d, sticky2_d, zero2_d, unf2_d, ovf2_d;
  logic [MW-1:0]        m2_d;
  logic [EW1-1:0]       exp2_d;
  logic [LZW-1:0]       lz;

  logic [WIDTH-1:0]     result_d;
  logic [2:0]           flags_d;
  logic [WIDTH_MAT:0]   kept;
  logic [WIDTH_MAT+1:0] rnd;
  logic [EW1-1:0]       exp3;
  logic                 g_bit, s_bit;

  // Backpressure chain: a stage moves when empty or when the next one moves.
  always_comb begin
    adv3     = !OUT_VALID || OUT_READY;
    adv2     = !v2 || adv3;
    adv1     = !v1 || adv2;
    IN_READY = adv1;
  end

  lzc_count #(.N(MW), .CW(LZW)) u_lzc (
    .din   (sum1[MW-1:0]),
    .count (lz)
  );

  // Normalise: right-shift on carry, otherwise left-shift by the leading-zero count.
  always_comb begin
    m2_d      = sum1[MW-1:0] << lz;
    sticky2_d = 1'b0;
    exp2_d    = {1'b0, exp1} - {{(EW1-LZW){1'b0}}, lz};
    zero2_d   = (sum1 == '0);
    unf2_d    = 1'b0;
    ovf2_d    = 1'b0;
    sign2_d   = zero2_d ? 1'b0 : sign1;
    if (sum1[MW]) begin
      m2_d      = sum1[MW:1];
      sticky2_d = sum1[0];
      exp2_d    = {1'b0, exp1} + EW1'(1);
      ovf2_d    = (exp2_d >= {1'b0, EXP_ONES});
    end else if (!zero2_d) begin
      unf2_d = ({1'b0, exp1} <= {{(EW1-LZW){1'b0}}, lz});
    end
  end

  // Round to nearest-even, then pack with exactly one exceptional flag at most.
  always_comb begin
    kept     = m2[MW-1:WIDTH_ROUND];
    g_bit    = m2[WIDTH_ROUND-1];
    s_bit    = (|m2[WIDTH_ROUND-2:0]) | sticky2;
    rnd      = {1'b0, kept} + {{(WIDTH_MAT+1){1'b0}}, (g_bit && (s_bit || kept[0]))};
    exp3     = exp2 + {{(EW1-1){1'b0}}, rnd[WIDTH_MAT+1]};
    result_d = pack_fp(sign2, exp3[WIDTH_EXP-1:0], rnd[WIDTH_MAT-1:0]);
    flags_d  = 3'b000;
    if (zero2) begin
      result_d          = '0;
      flags_d[FLAG_ZERO] = 1'b1;
    end else if (unf2) begin
      result_d          = pack_fp(sign2, '0, '0);
      flags_d[FLAG_UNF] = 1'b1;
    end else if (ovf2 || exp3 >= {1'b0, EXP_ONES}) begin
      result_d          = pack_fp(sign2, EXP_ONES, '0);
      flags_d[FLAG_OVF] = 1'b1;
    end
  end

  // Pipeline registers; reset clears every stage and wins over any transfer.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      v1 <= 1'b0; sign1 <= 1'b0; sum1 <= '0; exp1 <= '0;
      v2 <= 1'b0; sign2 <= 1'b0; sticky2 <= 1'b0; zero2 <= 1'b0;
      unf2 <= 1'b0; ovf2 <= 1'b0; m2 <= '0; exp2 <= '0;
      OUT_VALID <= 1'b0; RESULT <= '0; FLAGS <= '0;
    end else begin
      if (adv1) begin
        v1    <= IN_VALID;
        sign1 <= SIGN_L;
        exp1  <= EXP_L;
        sum1  <= (SIGN_L ^ SIGN_S) ? ({1'b0, MAT_L} - {1'b0, MAT_S})
                                   : ({1'b0, MAT_L} + {1'b0, MAT_S});
      end
      if (adv2) begin
        v2      <= v1;
        sign2   <= sign2_d;
        sticky2 <= sticky2_d;
        zero2   <= zero2_d;
        unf2    <= unf2_d;
        ovf2    <= ovf2_d;
        m2      <= m2_d;
        exp2    <= exp2_d;
      end
      if (adv3) begin
        OUT_VALID <= v2;
        RESULT    <= result_d;
        FLAGS     <= flags_d;
      end
    end
  end
endmodule
